mmss_timer: RTL and testbench

- Time-source stage that produces the packed {minute[5:0], second[5:0]} words consumed by the seven-segment decoder stage.
- Contains two channels:
  - a stopwatch that counts up and drives counter_out;
  - a countdown timer with a user-set preset that drives timer_out.
- Also drives the output_select mux control from a view button.
- Runs from the 100 Hz board clock and derives 1 s ticks with an internal prescaler.

---
 rtl/timer_pkg.sv | 24 ++
 rtl/btn_edge.sv | 33 +++
 rtl/mmss_timer.sv | 225 ++++++++++++++++++++++
 tb/tb_mmss_timer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared types and constants for the mm:ss time-source stage.
//   tm_state_t : countdown FSM state encoding (IDLE, RUN, PAUSE, DONE)
//   mmss_t     : packed {min[5:0], sec[5:0]} word as seen by the display stage
//   SEC_MAX    : largest seconds value (seconds always span 0..59)
// -----------------------------------------------------------------------------
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } tm_state_t;

    typedef struct packed {
        logic [5:0] min;
        logic [5:0] sec;
    } mmss_t;

    localparam logic [5:0] SEC_MAX = 6'd59;

endpackage

// File: rtl/btn_edge.sv
// -----------------------------------------------------------------------------
// btn_edge
// Synchronous rising-edge detector for one level-sensitive button.
// The history register resets to 1 so that a button held through reset
// produces no event until it has been released and pressed again.
// Ports:
//   clk   : system clock
//   reset : synchronous active-high reset
//   btn   : button level
//   rise  : high for the cycle where btn = 1 and the previous sample was 0
// -----------------------------------------------------------------------------
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    logic prev_r;

    // History register: previous sample of the button level.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_r <= 1'b1;
        end else begin
            prev_r <= btn;
        end
    end

    // Event is consumed at the same edge that sees the new level.
    assign rise = btn & ~prev_r;

endmodule

// File: rtl/mmss_timer.sv
// -----------------------------------------------------------------------------
// mmss_timer
// Stopwatch (counts up, drives counter_out) and countdown timer with a
// user preset (drives timer_out), each with its own 1 s prescaler, plus a
// registered view-select for the downstream display mux.
// Ports:
//   hz100         : system clock (100 Hz on the board)
//   reset         : synchronous active-high reset
//   sw_start      : stopwatch start/stop button (level)
//   sw_clear      : stopwatch clear button (level)
//   tm_start      : countdown start/pause/acknowledge button (level)
//   tm_clear      : countdown clear button (level)
//   set_min       : preset minute increment (level, IDLE only)
//   set_sec       : preset second increment (level, IDLE only)
//   view_sel      : 0 = stopwatch, 1 = countdown
//   counter_out   : stopwatch {min, sec}
//   timer_out     : countdown {min, sec}; shows the preset while IDLE
//   output_select : view_sel delayed by one cycle
//   sw_running    : stopwatch is counting
//   tm_running    : countdown FSM is in RUN
//   expired       : countdown FSM is in DONE
// -----------------------------------------------------------------------------
module mmss_timer
    import timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100,
    parameter int MAX_MIN       = 59
) (
    input  logic        hz100,
    input  logic        reset,
    input  logic        sw_start,
    input  logic        sw_clear,
    input  logic        tm_start,
    input  logic        tm_clear,
    input  logic        set_min,
    input  logic        set_sec,
    input  logic        view_sel,
    output logic [11:0] counter_out,
    output logic [11:0] timer_out,
    output logic        output_select,
    output logic        sw_running,
    output logic        tm_running,
    output logic        expired
);

    localparam int            PW         = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PRESC_TC   = PW'(TICKS_PER_SEC - 1);
    localparam logic [PW-1:0] PRESC_ZERO = PW'(0);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
    localparam logic [5:0]    MIN_MAX    = 6'(MAX_MIN);

    logic sw_start_ev_s, sw_clear_ev_s, tm_start_ev_s, tm_clear_ev_s;
    logic set_min_ev_s, set_sec_ev_s;

    btn_edge u_sw_start (.clk(hz100), .reset(reset), .btn(sw_start), .rise(sw_start_ev_s));
    btn_edge u_sw_clear (.clk(hz100), .reset(reset), .btn(sw_clear), .rise(sw_clear_ev_s));
    btn_edge u_tm_start (.clk(hz100), .reset(reset), .btn(tm_start), .rise(tm_start_ev_s));
    btn_edge u_tm_clear (.clk(hz100), .reset(reset), .btn(tm_clear), .rise(tm_clear_ev_s));
    btn_edge u_set_min  (.clk(hz100), .reset(reset), .btn(set_min),  .rise(set_min_ev_s));
    btn_edge u_set_sec  (.clk(hz100), .reset(reset), .btn(set_sec),  .rise(set_sec_ev_s));

    // ---------------- stopwatch channel ----------------
    mmss_t         sw_val_r, sw_inc_s;
    logic          sw_run_r;
    logic [PW-1:0] sw_presc_r;

    // Next stopwatch value: seconds wrap into minutes, MAX_MIN:59 wraps to 00:00.
    always_comb begin
        sw_inc_s = sw_val_r;
        if (sw_val_r.sec == SEC_MAX) begin
            sw_inc_s.sec = 6'd0;
            if (sw_val_r.min == MIN_MAX) begin
                sw_inc_s.min = 6'd0;
            end else begin
                sw_inc_s.min = sw_val_r.min + 6'd1;
            end
        end else begin
            sw_inc_s.sec = sw_val_r.sec + 6'd1;
        end
    end

    // Stopwatch state. An edge carrying a start/stop event does not advance
    // the prescaler; stopping holds it, starting from stopped zeroes it.
    always_ff @(posedge hz100) begin
        if (reset) begin
            sw_val_r   <= 12'h000;
            sw_run_r   <= 1'b0;
            sw_presc_r <= PRESC_ZERO;
        end else if (sw_clear_ev_s) begin
            sw_val_r   <= 12'h000;
            sw_run_r   <= 1'b0;
            sw_presc_r <= PRESC_ZERO;
        end else if (sw_start_ev_s) begin
            sw_run_r <= ~sw_run_r;
            if (!sw_run_r) begin
                sw_presc_r <= PRESC_ZERO;
            end
        end else if (sw_run_r) begin
            if (sw_presc_r == PRESC_TC) begin
                sw_presc_r <= PRESC_ZERO;
                sw_val_r   <= sw_inc_s;
            end else begin
                sw_presc_r <= sw_presc_r + PRESC_ONE;
            end
        end
    end

    // ---------------- countdown channel ----------------
    tm_state_t     tm_state_r;
    mmss_t         tm_val_r, tm_dec_s;
    mmss_t         preset_r, preset_nxt_s;
    logic [PW-1:0] tm_presc_r;

    // Preset edits apply only in IDLE; both fields may step in the same cycle.
    always_comb begin
        preset_nxt_s = preset_r;
        if (tm_state_r == IDLE) begin
            if (set_min_ev_s) begin
                preset_nxt_s.min = (preset_r.min == MIN_MAX) ? 6'd0 : preset_r.min + 6'd1;
            end else begin
                preset_nxt_s.min = preset_r.min;
            end
            if (set_sec_ev_s) begin
                preset_nxt_s.sec = (preset_r.sec == SEC_MAX) ? 6'd0 : preset_r.sec + 6'd1;
            end else begin
                preset_nxt_s.sec = preset_r.sec;
            end
        end else begin
            preset_nxt_s = preset_r;
        end
    end

    // Decrement with borrow. 00:00 is never decremented (RUN leaves at 00:01),
    // so the minute floor only keeps the field in range.
    always_comb begin
        tm_dec_s = tm_val_r;
        if (tm_val_r.sec == 6'd0) begin
            tm_dec_s.sec = SEC_MAX;
            if (tm_val_r.min == 6'd0) begin
                tm_dec_s.min = 6'd0;
            end else begin
                tm_dec_s.min = tm_val_r.min - 6'd1;
            end
        end else begin
            tm_dec_s.sec = tm_val_r.sec - 6'd1;
        end
    end

    // Countdown FSM, value and prescaler. Clear outranks start in every state.
    always_ff @(posedge hz100) begin
        if (reset) begin
            tm_state_r <= IDLE;
            tm_val_r   <= 12'h000;
            preset_r   <= 12'h000;
            tm_presc_r <= PRESC_ZERO;
        end else begin
            preset_r <= preset_nxt_s;
            if (tm_clear_ev_s) begin
                tm_state_r <= IDLE;
                tm_val_r   <= preset_nxt_s;
                tm_presc_r <= PRESC_ZERO;
            end else begin
                case (tm_state_r)
                    IDLE: begin
                        tm_val_r <= preset_nxt_s;
                        if (tm_start_ev_s && (preset_nxt_s != 12'h000)) begin
                            tm_state_r <= RUN;
                            tm_presc_r <= PRESC_ZERO;
                        end
                    end
                    RUN: begin
                        if (tm_start_ev_s) begin
                            tm_state_r <= PAUSE;
                        end else if (tm_presc_r == PRESC_TC) begin
                            tm_presc_r <= PRESC_ZERO;
                            if (tm_val_r == 12'h001) begin
                                tm_val_r   <= 12'h000;
                                tm_state_r <= DONE;
                            end else begin
                                tm_val_r <= tm_dec_s;
                            end
                        end else begin
                            tm_presc_r <= tm_presc_r + PRESC_ONE;
                        end
                    end
                    PAUSE: begin
                        if (tm_start_ev_s) begin
                            tm_state_r <= RUN;
                        end
                    end
                    DONE: begin
                        tm_val_r <= 12'h000;
                        if (tm_start_ev_s) begin
                            tm_state_r <= IDLE;
                            tm_val_r   <= preset_r;
                        end
                    end
                    default: begin
                        tm_state_r <= IDLE;
                        tm_val_r   <= preset_r;
                    end
                endcase
            end
        end
    end

    logic output_select_r;

    // View select is registered once for the display mux.
    always_ff @(posedge hz100) begin
        if (reset) begin
            output_select_r <= 1'b0;
        end else begin
            output_select_r <= view_sel;
        end
    end

    assign counter_out   = sw_val_r;
    assign timer_out     = tm_val_r;
    assign sw_running    = sw_run_r;
    assign tm_running    = (tm_state_r == RUN);
    assign expired       = (tm_state_r == DONE);
    assign output_select = output_select_r;

endmodule

// File: tb/tb_mmss_timer.sv
// -----------------------------------------------------------------------------
// tb_mmss_timer
// Self-checking bench for mmss_timer: directed scenarios plus randomized
// button traffic, every cycle compared against a behavioural model that keeps
// times as plain second counts.
// -----------------------------------------------------------------------------
module tb_mmss_timer;

    localparam int TPS    = 100;
    localparam int MAXM   = 3;
    localparam int SW_MOD = (MAXM + 1) * 60;

    localparam int B_SW_START = 0;
    localparam int B_SW_CLEAR = 1;
    localparam int B_TM_START = 2;
    localparam int B_TM_CLEAR = 3;
    localparam int B_SET_MIN  = 4;
    localparam int B_SET_SEC  = 5;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic        hz100 = 1'b0;
    logic        reset, sw_start, sw_clear, tm_start, tm_clear, set_min, set_sec, view_sel;
    logic [11:0] counter_out, timer_out;
    logic        output_select, sw_running, tm_running, expired;

    mmss_timer #(.TICKS_PER_SEC(TPS), .MAX_MIN(MAXM)) dut (
        .hz100(hz100), .reset(reset),
        .sw_start(sw_start), .sw_clear(sw_clear),
        .tm_start(tm_start), .tm_clear(tm_clear),
        .set_min(set_min), .set_sec(set_sec), .view_sel(view_sel),
        .counter_out(counter_out), .timer_out(timer_out),
        .output_select(output_select), .sw_running(sw_running),
        .tm_running(tm_running), .expired(expired)
    );

    always #5 hz100 = ~hz100;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit m_prev [6];
    int m_sw_secs, m_sw_phase;
    bit m_sw_run;
    int m_st, m_tm_secs, m_tm_phase, m_pm, m_ps;
    bit m_osel;

    function automatic logic [11:0] mmss(input int s);
        logic [5:0] mn, sc;
        mn = 6'(s / 60);
        sc = 6'(s % 60);
        return {mn, sc};
    endfunction

    task automatic model_step();
        bit lv [6];
        bit ev [6];
        int pm_n, ps_n;
        lv[B_SW_START] = sw_start; lv[B_SW_CLEAR] = sw_clear;
        lv[B_TM_START] = tm_start; lv[B_TM_CLEAR] = tm_clear;
        lv[B_SET_MIN]  = set_min;  lv[B_SET_SEC]  = set_sec;
        if (reset) begin
            for (int i = 0; i < 6; i++) m_prev[i] = 1'b1;
            m_sw_secs = 0; m_sw_phase = 0; m_sw_run = 1'b0;
            m_st = M_IDLE; m_tm_secs = 0; m_tm_phase = 0; m_pm = 0; m_ps = 0;
            m_osel = 1'b0;
            return;
        end
        for (int i = 0; i < 6; i++) begin
            ev[i] = lv[i] && !m_prev[i];
            m_prev[i] = lv[i];
        end
        m_osel = view_sel;

        // stopwatch
        if (ev[B_SW_CLEAR]) begin
            m_sw_secs = 0; m_sw_run = 1'b0; m_sw_phase = 0;
        end else if (ev[B_SW_START]) begin
            if (!m_sw_run) m_sw_phase = 0;
            m_sw_run = !m_sw_run;
        end else if (m_sw_run) begin
            m_sw_phase++;
            if (m_sw_phase == TPS) begin
                m_sw_phase = 0;
                m_sw_secs = (m_sw_secs + 1) % SW_MOD;
            end
        end

        // countdown
        pm_n = m_pm; ps_n = m_ps;
        if (m_st == M_IDLE) begin
            if (ev[B_SET_MIN]) pm_n = (m_pm + 1) % (MAXM + 1);
            if (ev[B_SET_SEC]) ps_n = (m_ps + 1) % 60;
        end
        if (ev[B_TM_CLEAR]) begin
            m_st = M_IDLE; m_tm_secs = pm_n * 60 + ps_n; m_tm_phase = 0;
        end else if (m_st == M_IDLE) begin
            m_tm_secs = pm_n * 60 + ps_n;
            if (ev[B_TM_START] && m_tm_secs != 0) begin
                m_st = M_RUN; m_tm_phase = 0;
            end
        end else if (m_st == M_RUN) begin
            if (ev[B_TM_START]) begin
                m_st = M_PAUSE;
            end else begin
                m_tm_phase++;
                if (m_tm_phase == TPS) begin
                    m_tm_phase = 0;
                    m_tm_secs--;
                    if (m_tm_secs == 0) m_st = M_DONE;
                end
            end
        end else if (m_st == M_PAUSE) begin
            if (ev[B_TM_START]) m_st = M_RUN;
        end else begin
            m_tm_secs = 0;
            if (ev[B_TM_START]) begin
                m_st = M_IDLE; m_tm_secs = m_pm * 60 + m_ps;
            end
        end
        m_pm = pm_n; m_ps = ps_n;
    endtask

    task automatic compare_model();
        check_eq("counter_out", counter_out, mmss(m_sw_secs));
        check_eq("timer_out", timer_out, mmss(m_tm_secs));
        check_eq("sw_running", sw_running, m_sw_run);
        check_eq("tm_running", tm_running, (m_st == M_RUN));
        check_eq("expired", expired, (m_st == M_DONE));
        check_eq("output_select", output_select, m_osel);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge hz100);
            model_step();
            #1;
            compare_model();
        end
    endtask

    task automatic drive(input int which, input logic v);
        case (which)
            B_SW_START: sw_start = v;
            B_SW_CLEAR: sw_clear = v;
            B_TM_START: tm_start = v;
            B_TM_CLEAR: tm_clear = v;
            B_SET_MIN:  set_min  = v;
            B_SET_SEC:  set_sec  = v;
            default:    ;
        endcase
    endtask

    // One edge with the button high, then released (no extra cycle).
    task automatic pulse(input int which);
        drive(which, 1'b1);
        cyc(1);
        drive(which, 1'b0);
    endtask

    // Full press: high for one edge, low for one edge.
    task automatic press(input int which);
        pulse(which);
        cyc(1);
    endtask

    initial begin
        reset = 1'b1; sw_start = 1'b1; sw_clear = 1'b0; tm_start = 1'b0;
        tm_clear = 1'b0; set_min = 1'b0; set_sec = 1'b0; view_sel = 1'b0;
        cyc(3);
        check_eq("rst_counter", counter_out, 12'h000);
        check_eq("rst_timer", timer_out, 12'h000);
        check_eq("rst_flags", {output_select, sw_running, tm_running, expired}, 4'b0000);

        // sw_start held through reset must not fire
        reset = 1'b0;
        cyc(5);
        check_eq("held_no_event", sw_running, 1'b0);
        sw_start = 1'b0;
        cyc(1);
        pulse(B_SW_START);
        check_eq("sw_started", sw_running, 1'b1);
        cyc(99);
        check_eq("sw_before_first_tick", counter_out, 12'h000);
        cyc(1);
        check_eq("sw_first_tick", counter_out, 12'h001);

        // sec wrap into minute, then full wrap at MAX_MIN:59
        cyc(58 * TPS);
        check_eq("sw_00_59", counter_out, 12'h03B);
        cyc(TPS);
        check_eq("sw_01_00", counter_out, 12'h040);
        cyc(179 * TPS);
        check_eq("sw_max", counter_out, {6'd3, 6'd59});
        cyc(TPS);
        check_eq("sw_wrap_zero", counter_out, 12'h000);
        check_eq("sw_wrap_running", sw_running, 1'b1);
        sw_clear = 1'b1; sw_start = 1'b1;
        cyc(1);
        sw_clear = 1'b0; sw_start = 1'b0;
        check_eq("sw_clear_wins_val", counter_out, 12'h000);
        check_eq("sw_clear_wins_run", sw_running, 1'b0);

        // preset editing
        view_sel = 1'b1;
        for (int i = 0; i < 61; i++) press(B_SET_SEC);
        check_eq("preset_sec_wrap", timer_out, 12'h001);
        check_eq("view_sel_reg", output_select, 1'b1);
        press(B_SET_MIN);
        press(B_SET_MIN);
        check_eq("preset_2_1", timer_out, {6'd2, 6'd1});
        set_min = 1'b1; set_sec = 1'b1;
        cyc(1);
        set_min = 1'b0; set_sec = 1'b0;
        cyc(1);
        check_eq("preset_both", timer_out, {6'd3, 6'd2});
        press(B_SET_MIN);
        check_eq("preset_min_wrap", timer_out, 12'h002);

        // countdown 00:02 to expiry
        pulse(B_TM_START);
        check_eq("tm_run", tm_running, 1'b1);
        cyc(99);
        check_eq("tm_hold_2", timer_out, 12'h002);
        cyc(1);
        check_eq("tm_00_01", timer_out, 12'h001);
        cyc(100);
        check_eq("tm_00_00", timer_out, 12'h000);
        check_eq("tm_expired", expired, 1'b1);
        check_eq("tm_not_running", tm_running, 1'b0);

        // clear beats start in DONE
        tm_clear = 1'b1; tm_start = 1'b1;
        cyc(1);
        tm_clear = 1'b0; tm_start = 1'b0;
        check_eq("done_clear_val", timer_out, 12'h002);
        check_eq("done_clear_exp", expired, 1'b0);
        check_eq("done_clear_idle", tm_running, 1'b0);

        // pause keeps value and prescaler
        cyc(1);
        press(B_SET_MIN);
        for (int i = 0; i < 58; i++) press(B_SET_SEC);
        check_eq("preset_1_0", timer_out, 12'h040);
        pulse(B_TM_START);
        cyc(50);
        pulse(B_TM_START);
        check_eq("paused", tm_running, 1'b0);
        cyc(500);
        check_eq("pause_hold", timer_out, 12'h040);
        pulse(B_TM_START);
        check_eq("resumed", tm_running, 1'b1);
        cyc(49);
        check_eq("resume_hold", timer_out, 12'h040);
        cyc(1);
        check_eq("resume_tick", timer_out, 12'h03B);

        // clear back to IDLE, then zero preset ignores start
        press(B_TM_CLEAR);
        check_eq("clear_reload", timer_out, 12'h040);
        for (int i = 0; i < 3; i++) press(B_SET_MIN);
        check_eq("preset_zero", timer_out, 12'h000);
        press(B_TM_START);
        check_eq("zero_start_ignored", tm_running, 1'b0);

        // dense random traffic: many coincident events
        for (int i = 0; i < 3000; i++) begin
            sw_start = ($urandom_range(0, 7) == 0);
            sw_clear = ($urandom_range(0, 15) == 0);
            tm_start = ($urandom_range(0, 7) == 0);
            tm_clear = ($urandom_range(0, 31) == 0);
            set_min  = ($urandom_range(0, 5) == 0);
            set_sec  = ($urandom_range(0, 3) == 0);
            view_sel = $urandom_range(0, 1);
            reset    = ($urandom_range(0, 999) == 0);
            cyc(1);
        end
        // sparse random traffic: lets seconds actually elapse
        reset = 1'b0;
        for (int i = 0; i < 15000; i++) begin
            sw_start = ($urandom_range(0, 399) == 0);
            sw_clear = ($urandom_range(0, 1999) == 0);
            tm_start = ($urandom_range(0, 299) == 0);
            tm_clear = ($urandom_range(0, 1999) == 0);
            set_min  = ($urandom_range(0, 99) == 0);
            set_sec  = ($urandom_range(0, 49) == 0);
            view_sel = ($urandom_range(0, 199) == 0) ? ~view_sel : view_sel;
            cyc(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
